// File: rtl/nmi_req_pkg.sv
// Shared definitions for the NMI request block: state encodings, status
// byte bit positions and the completed-NMI count width.
package nmi_req_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam int CNT_W          = 4;
    localparam int STAT_STATE_LSB = 6;
    localparam int STAT_TIMEOUT   = 5;
    localparam int STAT_OVERRUN   = 4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nmi_req_debounce.sv
// Front-panel NMI button conditioning: 2-flop synchroniser, stability
// down-counter, and a one-cycle press pulse on the debounced falling edge.
module nmi_debounce #(
    parameter int DEB_BITS = 16
) (
    input  logic fclk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press_o
);

    logic [1:0]          sync_q;
    logic                level_q, level_d;
    logic [DEB_BITS-1:0] cnt_q, cnt_d;
    logic                differ;

    assign differ = sync_q[1] ^ level_q;

    // Counter reloads whenever the input agrees with the debounced level, so
    // the level only flips after 2^DEB_BITS consecutive disagreeing cycles.
    always_comb begin
        cnt_d   = '1;
        level_d = level_q;
        if (differ) begin
            if (cnt_q == '0) level_d = sync_q[1];
            else             cnt_d   = cnt_q - 1'b1;
        end
    end

    assign press_o = differ & (cnt_q == '0) & ~sync_q[1];

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '1;
        end else begin
            sync_q  <= {sync_q[0], btn_n};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/nmi_req.sv
// NMI request FSM: turns slavespi requests (and, with NMI_BUTTON_EN defined,
// a debounced front-panel button) into toggles on set_nmi and reports status.
//
//  state  | meaning
//  IDLE   | no NMI outstanding, ready for a request
//  WAIT   | set_nmi toggled, waiting for the generator to raise in_nmi
//  ACTIVE | generator is inside its NMI window
module nmi_req
    import nmi_req_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 3,
    parameter int DEB_BITS       = 16
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       req_strobe,
    input  logic       stat_clr,
    input  logic       int_start,
    input  logic       in_nmi,
    input  logic       btn_n,
    output logic       set_nmi,
    output logic       nmi_busy,
    output logic [7:0] nmi_status
);

    localparam int               TO_W     = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_FRAMES);

    logic [1:0]       state_q, state_d;
    logic             set_q, set_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d, to_inc;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             btn_req, req;

`ifdef NMI_BUTTON_EN
    nmi_debounce #(.DEB_BITS(DEB_BITS)) u_debounce (
        .fclk    (fclk),
        .rst_n   (rst_n),
        .btn_n   (btn_n),
        .press_o (btn_req)
    );
`else
    localparam int DEB_BITS_UNUSED = DEB_BITS;
    logic btn_n_unused;
    assign btn_n_unused = btn_n;
    assign btn_req      = 1'b0;
`endif

    assign req    = req_strobe | btn_req;
    assign to_inc = to_cnt_q + 1'b1;

    // Clear is applied first so any same-cycle event overrides it.
    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        if (stat_clr) begin
            timeout_d = 1'b0;
            overrun_d = 1'b0;
            count_d   = '0;
        end
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!in_nmi) begin
                        set_d    = ~set_q;
                        to_cnt_d = '0;
                        state_d  = ST_WAIT;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (req) overrun_d = 1'b1;
                if (in_nmi) begin
                    state_d = ST_ACTIVE;
                end else if (int_start) begin
                    to_cnt_d = to_inc;
                    if (to_inc == TO_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (req) overrun_d = 1'b1;
                if (!in_nmi) begin
                    state_d = ST_IDLE;
                    count_d = sat_inc(count_d);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            set_q     <= 1'b0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            set_q     <= set_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        nmi_status                            = '0;
        nmi_status[STAT_STATE_LSB +: 2]       = state_q;
        nmi_status[STAT_TIMEOUT]              = timeout_q;
        nmi_status[STAT_OVERRUN]              = overrun_q;
        nmi_status[CNT_W-1:0]                 = count_q;
    end

    assign set_nmi  = set_q;
    assign nmi_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nmi_req.sv
// Self-checking bench for nmi_req: table-driven per-cycle vectors plus
// directed sequences for timing, saturation, reset and (NMI_BUTTON_EN) button.
module tb_nmi_req;

    logic       fclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_strobe = 1'b0;
    logic       stat_clr = 1'b0;
    logic       int_start = 1'b0;
    logic       in_nmi = 1'b0;
    logic       btn_n = 1'b1;
    logic       set_nmi;
    logic       nmi_busy;
    logic [7:0] nmi_status;

    int checks = 0;
    int errors = 0;

    nmi_req #(.TIMEOUT_FRAMES(3), .DEB_BITS(4)) dut (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .req_strobe (req_strobe),
        .stat_clr   (stat_clr),
        .int_start  (int_start),
        .in_nmi     (in_nmi),
        .btn_n      (btn_n),
        .set_nmi    (set_nmi),
        .nmi_busy   (nmi_busy),
        .nmi_status (nmi_status)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic       req;
        logic       clr;
        logic       ints;
        logic       inn;
        logic       exp_set;
        logic       exp_busy;
        logic [7:0] exp_stat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_strobe = 1'b0; stat_clr = 1'b0; int_start = 1'b0; in_nmi = 1'b0;
        repeat (3) tick();
        check("rst set_nmi", {7'b0, set_nmi}, 8'h00);
        check("rst busy", {7'b0, nmi_busy}, 8'h00);
        check("rst status", nmi_status, 8'h00);
        rst_n = 1'b1;
    endtask

    int lat;
    int toggles;
    logic prev;

    initial begin
        // req clr int in | set busy status
        vecs.push_back('{0,0,0,0, 0,0,8'h00});
        vecs.push_back('{1,0,0,0, 1,1,8'h40});
        vecs.push_back('{0,0,1,0, 1,1,8'h40});
        vecs.push_back('{0,0,0,1, 1,1,8'h80});
        vecs.push_back('{0,0,1,1, 1,1,8'h80});
        vecs.push_back('{1,0,0,1, 1,1,8'h90});
        vecs.push_back('{0,0,0,0, 1,0,8'h11});
        vecs.push_back('{0,1,0,0, 1,0,8'h00});
        vecs.push_back('{1,0,0,0, 0,1,8'h40});
        vecs.push_back('{0,0,1,0, 0,1,8'h40});
        vecs.push_back('{0,0,1,0, 0,1,8'h40});
        vecs.push_back('{0,0,1,0, 0,0,8'h20});
        vecs.push_back('{1,0,0,1, 0,0,8'h30});
        vecs.push_back('{0,1,0,0, 0,0,8'h00});
        vecs.push_back('{1,0,0,0, 1,1,8'h40});
        vecs.push_back('{1,1,0,0, 1,1,8'h50});
        vecs.push_back('{0,0,0,1, 1,1,8'h90});
        vecs.push_back('{0,1,0,1, 1,1,8'h80});
        vecs.push_back('{0,0,0,0, 1,0,8'h01});
        vecs.push_back('{1,0,0,0, 0,1,8'h41});
        vecs.push_back('{0,0,0,1, 0,1,8'h81});
        vecs.push_back('{0,1,0,0, 0,0,8'h01});
        vecs.push_back('{1,0,0,0, 1,1,8'h41});
        vecs.push_back('{0,0,1,0, 1,1,8'h41});
        vecs.push_back('{0,0,1,0, 1,1,8'h41});
        vecs.push_back('{0,0,1,1, 1,1,8'h81});
        vecs.push_back('{0,0,0,0, 1,0,8'h02});
        vecs.push_back('{0,1,0,0, 1,0,8'h00});

        do_reset();
        foreach (vecs[i]) begin
            req_strobe = vecs[i].req;
            stat_clr   = vecs[i].clr;
            int_start  = vecs[i].ints;
            in_nmi     = vecs[i].inn;
            tick();
            check($sformatf("vec%0d set_nmi", i), {7'b0, set_nmi}, {7'b0, vecs[i].exp_set});
            check($sformatf("vec%0d busy", i), {7'b0, nmi_busy}, {7'b0, vecs[i].exp_busy});
            check($sformatf("vec%0d status", i), nmi_status, vecs[i].exp_stat);
        end
        req_strobe = 0; stat_clr = 0; int_start = 0; in_nmi = 0;

        // Nominal NMI with absolute cycle timing after reset release.
        do_reset();
        for (int c = 1; c <= 210; c++) begin
            req_strobe = (c == 10);
            in_nmi     = (c >= 40 && c < 200);
            tick();
            if (c == 9)   check("nom set before", {7'b0, set_nmi}, 8'h00);
            if (c == 10)  check("nom set toggled", {7'b0, set_nmi}, 8'h01);
            if (c == 10)  check("nom wait", nmi_status, 8'h40);
            if (c == 39)  check("nom wait end", nmi_status, 8'h40);
            if (c == 40)  check("nom active", nmi_status, 8'h80);
            if (c == 199) check("nom active end", nmi_status, 8'h80);
            if (c == 200) check("nom done", nmi_status, 8'h01);
            if (c == 201) check("nom busy low", {7'b0, nmi_busy}, 8'h00);
        end
        req_strobe = 0; in_nmi = 0;

        // Saturation over 17 complete NMIs, then reset in WAIT.
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            req_strobe = 1; tick();
            req_strobe = 0; in_nmi = 1; tick();
            in_nmi = 0; tick();
            check($sformatf("sat n=%0d", n), nmi_status, (n > 15) ? 8'h0F : 8'(n));
        end
        req_strobe = 1; tick();
        req_strobe = 0;
        check("sat wait", nmi_status, 8'h4F);
        rst_n = 1'b0;
        tick();
        check("mid rst status", nmi_status, 8'h00);
        check("mid rst set", {7'b0, set_nmi}, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post rst status", nmi_status, 8'h00);
        check("post rst set", {7'b0, set_nmi}, 8'h00);
        check("post rst busy", {7'b0, nmi_busy}, 8'h00);

`ifdef NMI_BUTTON_EN
        do_reset();
        repeat (5) tick();
        btn_n = 1'b0;
        repeat (10) tick();
        btn_n = 1'b1;
        repeat (30) tick();
        check("btn glitch ignored", {7'b0, set_nmi}, 8'h00);
        prev = set_nmi;
        lat = 0;
        toggles = 0;
        btn_n = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (set_nmi !== prev) begin
                toggles++;
                if (lat == 0) lat = c;
            end
            prev = set_nmi;
        end
        btn_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (set_nmi !== prev) toggles++;
            prev = set_nmi;
        end
        check("btn one request", 8'(toggles), 8'd1);
        check("btn latency in 16..18", {7'b0, (lat >= 16 && lat <= 18)}, 8'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
